// File: rtl/axi_cmd_pkg.sv
// Shared types and constants for the AXI command sequencer.
// Descriptor layout: [15:8] addr, [7:4] len (beats-1), [3:0] id.
package axi_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT_R = 3'd2,
        WAIT_W = 3'd3,
        RESP   = 3'd4
    } state_e;

    localparam int ADDR_MSB  = 15;
    localparam int ADDR_LSB  = 8;
    // Fields are contiguous: len sits directly below addr.
    localparam int LEN_MSB   = ADDR_LSB - 1;
    localparam int LEN_LSB   = 4;
    localparam int ID_MSB    = 3;
    localparam int ID_LSB    = 0;
    localparam int DESC_W    = ADDR_MSB + 1;

    localparam int BEAT_W    = 8;
    localparam int MAX_BEATS = 16;
    localparam int DATA_W    = BEAT_W * MAX_BEATS;
    localparam int CMD_W     = 1 + DESC_W + DATA_W;

    typedef struct packed {
        logic              wr;
        logic [DESC_W-1:0] desc;
        logic [DATA_W-1:0] data;
    } cmd_t;

    // Number of beats a descriptor asks for (len + 1), 5 bits so 16 fits.
    function automatic logic [4:0] beats_expected(input logic [DESC_W-1:0] desc);
        return {1'b0, desc[LEN_MSB:LEN_LSB]} + 5'd1;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: DEPTH entries of WIDTH bits, first-word-fall-through read.
// Pushes into a full queue and pops from an empty queue are ignored.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 145
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_s;
    logic             pop_s;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == (PTR_W+1)'(0));
    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // Storage array; written only on an accepted push.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/axi_cmd_sequencer.sv
// Host-side command stage feeding the AXI Master: queues commands, launches one
// at a time, watches the R/B channels for completion and returns one response.
// Optional watchdog: define CMD_TIMEOUT_EN to bound the WAIT_R/WAIT_W states.
module axi_cmd_sequencer
    import axi_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TMO_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_wr,
    input  logic [DESC_W-1:0]  cmd_desc,
    input  logic [DATA_W-1:0]  cmd_data,
    output logic               en,
    output logic               en_,
    output logic [DESC_W-1:0]  tb_R,
    output logic [DESC_W-1:0]  tb_W,
    output logic [DATA_W-1:0]  INDATA,
    input  logic               RVALID,
    input  logic               RREADY,
    input  logic               RLAST,
    input  logic [BEAT_W-1:0]  RDATA,
    input  logic               RRESP,
    input  logic               BVALID,
    input  logic               BREADY,
    input  logic [4:0]         BRESP,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_wr,
    output logic [3:0]         rsp_id,
    output logic               rsp_err,
    output logic [DATA_W-1:0]  rsp_data
);

    state_e             state_q, state_d;
    logic               en_q, en_d, enw_q, enw_d;
    logic [DESC_W-1:0]  tb_r_q, tb_r_d, tb_w_q, tb_w_d;
    logic [DATA_W-1:0]  indata_q, indata_d;
    logic               rsp_valid_q, rsp_valid_d, rsp_wr_q, rsp_wr_d;
    logic               rsp_err_q, rsp_err_d;
    logic [3:0]         rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [4:0]         beat_q, beat_d;

    cmd_t               head_s;
    logic               fifo_full_s, fifo_empty_s, pop_s;
    logic               rd_hs_s, wr_hs_s, tmo_hit_s;

    assign rd_hs_s = (state_q == WAIT_R) && RVALID && RREADY;
    assign wr_hs_s = (state_q == WAIT_W) && BVALID && BREADY;

    cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (cmd_valid),
        .din_i   ({cmd_wr, cmd_desc, cmd_data}),
        .pop_i   (pop_s),
        .dout_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign cmd_ready = !fifo_full_s;

`ifdef CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;

    assign tmo_hit_s = ((state_q == WAIT_R) || (state_q == WAIT_W)) && !rd_hs_s && !wr_hs_s
                       && (tmo_q == TMO_W'(TMO_CYCLES - 1));

    // Watchdog: counts idle wait cycles, restarts on every channel handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (((state_q == WAIT_R) || (state_q == WAIT_W)) && !rd_hs_s && !wr_hs_s && !tmo_hit_s) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end else begin
            tmo_q <= '0;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state and next-output logic for the command FSM.
    always_comb begin
        state_d     = state_q;
        en_d        = 1'b0;
        enw_d       = 1'b0;
        tb_r_d      = tb_r_q;
        tb_w_d      = tb_w_q;
        indata_d    = indata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        beat_d      = beat_q;
        pop_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    state_d    = ISSUE;
                    en_d       = !head_s.wr;
                    enw_d      = head_s.wr;
                    tb_r_d     = head_s.wr ? '0 : head_s.desc;
                    tb_w_d     = head_s.wr ? head_s.desc : '0;
                    indata_d   = head_s.wr ? head_s.data : '0;
                    rsp_wr_d   = head_s.wr;
                    rsp_id_d   = head_s.desc[ID_MSB:ID_LSB];
                    rsp_err_d  = 1'b0;
                    rsp_data_d = '0;
                    beat_d     = 5'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = rsp_wr_q ? WAIT_W : WAIT_R;
            end
            WAIT_R: begin
                if (rd_hs_s) begin
                    if (beat_q < 5'(MAX_BEATS)) begin
                        rsp_data_d[{beat_q[3:0], 3'b000} +: BEAT_W] = RDATA;
                    end else begin
                        rsp_data_d = rsp_data_q;
                    end
                    beat_d = (beat_q == 5'd31) ? beat_q : beat_q + 5'd1;
                    if (RRESP || (RLAST && (beat_d != beats_expected(tb_r_q)))) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        rsp_err_d = rsp_err_q;
                    end
                    if (RLAST) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = WAIT_R;
                    end
                end else if (tmo_hit_s) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    state_d = WAIT_R;
                end
            end
            WAIT_W: begin
                if (wr_hs_s) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (BRESP != 5'd0);
                end else if (tmo_hit_s) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    state_d = WAIT_W;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            enw_q       <= 1'b0;
            tb_r_q      <= '0;
            tb_w_q      <= '0;
            indata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_id_q    <= 4'd0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            beat_q      <= 5'd0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            enw_q       <= enw_d;
            tb_r_q      <= tb_r_d;
            tb_w_q      <= tb_w_d;
            indata_q    <= indata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            beat_q      <= beat_d;
        end
    end

    assign en        = en_q;
    assign en_       = enw_q;
    assign tb_R      = tb_r_q;
    assign tb_W      = tb_w_q;
    assign INDATA    = indata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_axi_cmd_sequencer.sv
// Bench for axi_cmd_sequencer: the bench plays host, Master and Slave channel
// driver; expected responses go into a scoreboard queue when a command is pushed
// and are compared when the DUT hands a response to the host.
module tb_axi_cmd_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, cmd_wr;
    logic [15:0]  cmd_desc;
    logic [127:0] cmd_data;
    logic         en, en_;
    logic [15:0]  tb_R, tb_W;
    logic [127:0] INDATA;
    logic         RVALID, RREADY, RLAST, RRESP;
    logic [7:0]   RDATA;
    logic         BVALID, BREADY;
    logic [4:0]   BRESP;
    logic         rsp_valid, rsp_ready, rsp_wr, rsp_err;
    logic [3:0]   rsp_id;
    logic [127:0] rsp_data;

    typedef struct {
        logic         wr;
        logic [3:0]   id;
        logic         err;
        logic [127:0] data;
    } exp_t;

    exp_t sb[$];
    int   total_cnt = 0;
    int   bad_cnt   = 0;
    logic [127:0] pay1;

    always #5 clk = ~clk;

    axi_cmd_sequencer #(.FIFO_DEPTH(4), .TMO_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_desc(cmd_desc), .cmd_data(cmd_data),
        .en(en), .en_(en_), .tb_R(tb_R), .tb_W(tb_W), .INDATA(INDATA),
        .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RDATA(RDATA), .RRESP(RRESP),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_data(rsp_data)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Response monitor: a handshake seen at negedge completes on the next posedge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                check("rsp_wr",   rsp_wr,   e.wr);
                check("rsp_id",   rsp_id,   e.id);
                check("rsp_err",  rsp_err,  e.err);
                check("rsp_data", rsp_data, e.data);
            end
        end
    end

    function automatic logic [127:0] rd_expect(input logic [127:0] pay, input int n);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < n && i < 16; i++) r[8*i +: 8] = pay[8*i +: 8];
        return r;
    endfunction

    function automatic logic rd_err(input logic [15:0] desc, input int n, input int err_beat);
        return (n != int'(desc[7:4]) + 1) || (err_beat >= 0 && err_beat < n);
    endfunction

    task automatic push_cmd(input logic wr, input logic [15:0] desc, input logic [127:0] data,
                            input logic e_err, input logic [127:0] e_data);
        exp_t e;
        int   ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready === 1'b1) begin ok = 1; break; end
            step(1);
        end
        if (ok == 0) check("push_ready_tmo", 1'b0, 1'b1);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_desc = desc; cmd_data = data;
        e.wr = wr; e.id = desc[3:0]; e.err = e_err; e.data = e_data;
        sb.push_back(e);
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_issue(input logic wr, input string tag);
        int ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if ((wr ? en_ : en) === 1'b1) begin ok = 1; break; end
            step(1);
        end
        if (ok == 0) check({tag, "_issue_tmo"}, 1'b0, 1'b1);
    endtask

    task automatic issue_write(input logic [15:0] desc, input logic [127:0] data);
        wait_issue(1'b1, "wr");
        check("tb_W", tb_W, desc);
        check("INDATA", INDATA, data);
        check("tb_R_idle", tb_R, 16'h0);
        check("en_quiet", en, 1'b0);
        step(1);
        check("en__pulse", en_, 1'b0);
    endtask

    task automatic b_hs(input logic [4:0] bresp);
        BVALID = 1'b1; BREADY = 1'b1; BRESP = bresp;
        step(1);
        BVALID = 1'b0; BREADY = 1'b0; BRESP = 5'd0;
    endtask

    task automatic serve_write(input logic [15:0] desc, input logic [127:0] data, input logic [4:0] bresp);
        issue_write(desc, data);
        b_hs(bresp);
    endtask

    task automatic serve_read(input logic [15:0] desc, input int n, input logic [127:0] pay, input int err_beat);
        wait_issue(1'b0, "rd");
        check("tb_R", tb_R, desc);
        check("tb_W_idle", tb_W, 16'h0);
        check("INDATA_idle", INDATA, 128'h0);
        step(1);
        check("en_pulse", en, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i == 3) begin
                RVALID = 1'b1; RREADY = 1'b0; RDATA = 8'hEE; RLAST = 1'b0; RRESP = 1'b1;
                step(1);
            end
            RVALID = 1'b1; RREADY = 1'b1;
            RDATA  = (i < 16) ? pay[8*i +: 8] : 8'hFF;
            RLAST  = (i == n - 1);
            RRESP  = (i == err_beat);
            step(1);
        end
        RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0; RRESP = 1'b0; RDATA = 8'h00;
    endtask

    task automatic no_issue(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, {en, en_}, 2'b00);
            step(1);
        end
    endtask

    initial begin
        logic [127:0] pay2;
        int           n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_desc = '0; cmd_data = '0;
        RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0; RDATA = '0; RRESP = 1'b0;
        BVALID = 1'b0; BREADY = 1'b0; BRESP = '0; rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) pay1[8*i +: 8] = 8'(i % 4 + 1);
        step(3);
        check("rst_outs", {en, en_, rsp_valid, rsp_wr, rsp_err, rsp_id}, 9'h0);
        check("rst_desc", {tb_R, tb_W}, 32'h0);
        check("rst_data", INDATA | rsp_data, 128'h0);
        check("rst_ready", cmd_ready, 1'b1);
        rst = 1'b0;
        step(1);

        // Basic write then read-back of the same payload.
        push_cmd(1'b1, 16'h01F1, pay1, 1'b0, 128'h0);
        serve_write(16'h01F1, pay1, 5'd0);
        step(2);
        push_cmd(1'b0, 16'h01F1, 128'hDEAD, 1'b0, pay1);
        serve_read(16'h01F1, 16, pay1, -1);
        step(2);

        // Queue full: one command stuck in WAIT_W, four more fill the queue.
        push_cmd(1'b1, 16'h1002, 128'hAA, 1'b0, 128'h0);
        issue_write(16'h1002, 128'hAA);
        push_cmd(1'b0, 16'h3003, 128'hDEAD, 1'b0, 128'h33);
        push_cmd(1'b1, 16'h4004, 128'h44, 1'b0, 128'h0);
        push_cmd(1'b0, 16'h5005, 128'hDEAD, 1'b0, 128'h55);
        push_cmd(1'b1, 16'h6006, 128'h66, 1'b0, 128'h0);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_desc = 16'h7007; cmd_data = 128'h77;
        for (int i = 0; i < 3; i++) begin
            check("full_ready", cmd_ready, 1'b0);
            step(1);
        end
        cmd_valid = 1'b0;
        b_hs(5'd0);
        serve_read(16'h3003, 1, 128'h33, -1);
        serve_write(16'h4004, 128'h44, 5'd0);
        serve_read(16'h5005, 1, 128'h55, -1);
        serve_write(16'h6006, 128'h66, 5'd0);
        step(1);
        no_issue("full_drop", 6);

        // Error cases: bad BRESP, short burst, RRESP, overlong burst.
        push_cmd(1'b1, 16'h0717, 128'h17, 1'b1, 128'h0);
        serve_write(16'h0717, 128'h17, 5'h02);
        push_cmd(1'b0, 16'h2034, 128'hDEAD, rd_err(16'h2034, 2, -1), rd_expect(128'hC2C1, 2));
        serve_read(16'h2034, 2, 128'hC2C1, -1);
        push_cmd(1'b0, 16'h0018, 128'hDEAD, rd_err(16'h0018, 2, 0), rd_expect(128'hD2D1, 2));
        serve_read(16'h0018, 2, 128'hD2D1, 0);
        pay2 = {$urandom, $urandom, $urandom, $urandom};
        push_cmd(1'b0, 16'h08F9, 128'hDEAD, rd_err(16'h08F9, 17, -1), rd_expect(pay2, 17));
        serve_read(16'h08F9, 17, pay2, -1);
        step(2);

        // Response backpressure with a second command waiting.
        rsp_ready = 1'b0;
        push_cmd(1'b1, 16'h0909, 128'h99, 1'b0, 128'h0);
        push_cmd(1'b1, 16'h0A0A, 128'hAA, 1'b0, 128'h0);
        serve_write(16'h0909, 128'h99, 5'd0);
        for (int i = 0; i < 10; i++) begin
            check("bp_fields", {rsp_valid, rsp_wr, rsp_err, rsp_id}, 7'b1_1_0_1001);
            check("bp_no_issue", {en, en_}, 2'b00);
            step(1);
        end
        rsp_ready = 1'b1;
        step(1);
        check("bp_done", rsp_valid, 1'b0);
        serve_write(16'h0A0A, 128'hAA, 5'd0);
        step(2);

        // Reset in WAIT_R with another command queued.
        push_cmd(1'b0, 16'h0F0B, 128'hDEAD, 1'b0, 128'h0);
        push_cmd(1'b1, 16'h0F0C, 128'hCC, 1'b0, 128'h0);
        wait_issue(1'b0, "rst_rd");
        step(1);
        RVALID = 1'b1; RREADY = 1'b0;
        rst = 1'b1;
        #1;
        sb.delete();
        check("rst_mid_outs", {en, en_, rsp_valid, tb_R, tb_W}, 35'h0);
        check("rst_mid_data", INDATA | rsp_data, 128'h0);
        step(1);
        RVALID = 1'b0;
        rst = 1'b0;
        check("rst_mid_ready", cmd_ready, 1'b1);
        no_issue("rst_queue_empty", 10);

`ifdef CMD_TIMEOUT_EN
        push_cmd(1'b1, 16'h0C0D, 128'hDD, 1'b1, 128'h0);
        wait_issue(1'b1, "tmo");
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        check("tmo_latency", (n >= 16 && n <= 18), 1'b1);
        step(2);
`else
        n = 0;
`endif

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
